// File: rtl/crcu_pkg.sv
// Shared constants and types for the CRCU APB register block: register map,
// field positions, reset values and the APB protocol FSM state type.
package crcu_pkg;

  localparam logic [7:0] ADDR_RST_CTL = 8'h00;
  localparam logic [7:0] ADDR_CLK_CTL = 8'h04;
  localparam logic [7:0] ADDR_RST_STS = 8'h08;
  localparam logic [7:0] ADDR_ID      = 8'h0C;

  localparam int unsigned RST_DUR_MSB  = 18;
  localparam int unsigned RST_DUR_LSB  = 3;
  localparam int unsigned SPARE_MSB    = 2;
  localparam int unsigned SPARE_LSB    = 1;
  localparam int unsigned SOFT_RST_BIT = 0;

  localparam int unsigned STS_LIVE_BIT  = 0;
  localparam int unsigned STS_DONE_BIT  = 1;
  localparam int unsigned STS_DZERO_BIT = 2;

  localparam logic [7:0]  CLK_CTL_RESET = 8'hFF;
  localparam logic [1:0]  SPARE_RESET   = 2'b00;
  localparam logic [15:0] RST_DUR_MIN   = 16'h0001;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Word-aligned match; byte-offset bits are ignored.
  function automatic logic addr_hit(input logic [7:0] paddr, input logic [7:0] reg_addr);
    return paddr[7:2] == reg_addr[7:2];
  endfunction

endpackage

// File: rtl/crcu_apb_fsm.sv
// APB completer protocol FSM with programmable wait states; produces PREADY
// and a write-commit strobe. Register storage lives in the parent.
module crcu_apb_fsm
  import crcu_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic pready,
  output logic commit
);

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [1:0] wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    pready  = 1'b0;
    unique case (state_q)
      IDLE:   if (psel && !penable) state_d = SETUP;
      SETUP:  state_d = (psel && penable) ? ACCESS : IDLE;
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          pready  = 1'b1;
          state_d = !penable ? SETUP : IDLE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = pready && pwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: rtl/crcu_apb_regs.sv
// CRCU reset/clock control register block on APB. Optional error responses
// are enabled by defining CRCU_APB_PSLVERR_EN.
module crcu_apb_regs
  import crcu_pkg::*;
#(
  parameter int unsigned WAIT_STATES     = 0,
  parameter logic [15:0] RST_DUR_DEFAULT = 16'h0010,
  parameter logic [31:0] ID_VALUE        = 32'h4352_0100
) (
  input  logic        CRCU_CLK,
  input  logic        CRCU_RST_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] rst_ctl_reg,
  output logic [7:0]  clk_ctl_reg,
  input  logic        rst_in
);

  logic        soft_rst_q, soft_rst_d;
  logic [1:0]  spare_q, spare_d;
  logic [15:0] rst_dur_q, rst_dur_d;
  logic [7:0]  clk_ctl_q, clk_ctl_d;
  logic        live_q, live_d, prev_q, prev_d;
  logic        done_q, done_d, dzero_q, dzero_d;

  logic        commit, wr, err_cond;
  logic        hit_rst, hit_clk, hit_sts, hit_id, mapped;
  logic [15:0] wr_dur;
  logic [31:0] rdata;
  logic        unused_bits;

  crcu_apb_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk    (CRCU_CLK),
    .rst_n  (CRCU_RST_N),
    .psel   (PSEL),
    .penable(PENABLE),
    .pwrite (PWRITE),
    .pready (PREADY),
    .commit (commit)
  );

  assign hit_rst = addr_hit(PADDR, ADDR_RST_CTL);
  assign hit_clk = addr_hit(PADDR, ADDR_CLK_CTL);
  assign hit_sts = addr_hit(PADDR, ADDR_RST_STS);
  assign hit_id  = addr_hit(PADDR, ADDR_ID);
  assign mapped  = hit_rst || hit_clk || hit_sts || hit_id;
  assign wr_dur  = PWDATA[RST_DUR_MSB:RST_DUR_LSB];
  assign unused_bits = ^{PWDATA[31:19], PADDR[1:0]};

`ifdef CRCU_APB_PSLVERR_EN
  assign err_cond = !mapped || (PWRITE && hit_id) ||
                    (PWRITE && hit_sts && PWDATA[STS_LIVE_BIT]);
`else
  assign err_cond = 1'b0 && mapped;
`endif

  assign PSLVERR = PREADY && err_cond;
  assign wr      = commit && !err_cond;

  always_comb begin
    soft_rst_d = 1'b0;
    spare_d    = spare_q;
    rst_dur_d  = rst_dur_q;
    clk_ctl_d  = clk_ctl_q;
    live_d     = rst_in;
    prev_d     = live_q;
    done_d     = done_q;
    dzero_d    = dzero_q;
    if (wr && hit_rst) begin
      soft_rst_d = PWDATA[SOFT_RST_BIT];
      spare_d    = PWDATA[SPARE_MSB:SPARE_LSB];
      rst_dur_d  = (wr_dur == '0) ? RST_DUR_MIN : wr_dur;
    end
    if (wr && hit_clk) clk_ctl_d = PWDATA[7:0];
    if (wr && hit_sts) begin
      if (PWDATA[STS_DONE_BIT])  done_d  = 1'b0;
      if (PWDATA[STS_DZERO_BIT]) dzero_d = 1'b0;
    end
    // Hardware set events are applied after W1C so a same-cycle set wins.
    if (prev_q && !live_q) done_d = 1'b1;
    if (wr && hit_rst && wr_dur == '0) dzero_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (hit_rst) begin
      rdata[RST_DUR_MSB:RST_DUR_LSB] = rst_dur_q;
      rdata[SPARE_MSB:SPARE_LSB]     = spare_q;
    end else if (hit_clk) begin
      rdata[7:0] = clk_ctl_q;
    end else if (hit_sts) begin
      rdata[STS_LIVE_BIT]  = live_q;
      rdata[STS_DONE_BIT]  = done_q;
      rdata[STS_DZERO_BIT] = dzero_q;
    end else if (hit_id) begin
      rdata = ID_VALUE;
    end
    PRDATA = (PREADY && !PWRITE) ? rdata : '0;

    rst_ctl_reg = '0;
    rst_ctl_reg[RST_DUR_MSB:RST_DUR_LSB] = rst_dur_q;
    rst_ctl_reg[SPARE_MSB:SPARE_LSB]     = spare_q;
    rst_ctl_reg[SOFT_RST_BIT]            = soft_rst_q;
  end

  assign clk_ctl_reg = clk_ctl_q;

  always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
    if (!CRCU_RST_N) begin
      soft_rst_q <= 1'b0;
      spare_q    <= SPARE_RESET;
      rst_dur_q  <= RST_DUR_DEFAULT;
      clk_ctl_q  <= CLK_CTL_RESET;
      live_q     <= 1'b0;
      prev_q     <= 1'b0;
      done_q     <= 1'b0;
      dzero_q    <= 1'b0;
    end else begin
      soft_rst_q <= soft_rst_d;
      spare_q    <= spare_d;
      rst_dur_q  <= rst_dur_d;
      clk_ctl_q  <= clk_ctl_d;
      live_q     <= live_d;
      prev_q     <= prev_d;
      done_q     <= done_d;
      dzero_q    <= dzero_d;
    end
  end

endmodule

// File: tb/tb_crcu_apb_regs.sv
// Scoreboard bench for crcu_apb_regs: drivers queue expected APB responses,
// an independent monitor checks them when PREADY is seen.
module tb_crcu_apb_regs;

  localparam int unsigned WS = 2;
  localparam logic [31:0] ID = 32'h4352_0100;
`ifdef CRCU_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, rst_n, psel, penable, pwrite, rst_in;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata, rst_ctl_reg;
  logic        pready, pslverr;
  logic [7:0]  clk_ctl_reg;

  crcu_apb_regs #(
    .WAIT_STATES    (WS),
    .RST_DUR_DEFAULT(16'h0010),
    .ID_VALUE       (ID)
  ) dut (
    .CRCU_CLK   (clk),
    .CRCU_RST_N (rst_n),
    .PSEL       (psel),
    .PENABLE    (penable),
    .PWRITE     (pwrite),
    .PADDR      (paddr),
    .PWDATA     (pwdata),
    .PRDATA     (prdata),
    .PREADY     (pready),
    .PSLVERR    (pslverr),
    .rst_ctl_reg(rst_ctl_reg),
    .clk_ctl_reg(clk_ctl_reg),
    .rst_in     (rst_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    bit          err;
    int unsigned cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   xfer_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pready: got PREADY=1 expected no pending transfer (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("xfer%0d_pslverr", mon_e.id), {31'b0, pslverr}, {31'b0, mon_e.err});
        chk($sformatf("xfer%0d_latency", mon_e.id), cyc, mon_e.cyc);
        if (mon_e.is_rd) chk($sformatf("xfer%0d_prdata", mon_e.id), prdata, mon_e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; that cycle is the bus setup cycle.
  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    int   n;
    xfer_id++;
    e.is_rd = !wr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = cyc + 2 + WS;
    e.id    = xfer_id;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pready !== 1'b1 && n < 20);
    if (pready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer%0d_timeout: got no PREADY expected PREADY within 20 cycles", xfer_id);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit err);
    apb(1'b1, a, d, 32'h0, err);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input bit err);
    apb(1'b0, a, 32'h0, exp, err);
  endtask

  // rst_in high for 5 cycles; falls in the cycle 5 after the call.
  task automatic pulse();
    rst_in = 1'b1;
    repeat (5) tick();
    rst_in = 1'b0;
  endtask

  // STS read whose PREADY lands d+4 cycles after the pulse starts.
  task automatic pulse_read(input int d, input logic [31:0] exp);
    fork
      pulse();
      begin
        repeat (d) tick();
        rd(8'h08, exp, 1'b0);
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst_in = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    chk("rst_rst_ctl", rst_ctl_reg, 32'h0000_0080);
    chk("rst_clk_ctl", {24'b0, clk_ctl_reg}, 32'h0000_00FF);
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    rst_n = 1'b1;
    tick();

    rd(8'h00, 32'h0000_0080, 1'b0);
    rd(8'h04, 32'h0000_00FF, 1'b0);
    rd(8'h08, 32'h0, 1'b0);
    rd(8'h0C, ID, 1'b0);

    wr(8'h00, 32'h0000_0401, 1'b0);
    chk("soft_rst_pulse", rst_ctl_reg, 32'h0000_0401);
    tick();
    chk("soft_rst_clear", rst_ctl_reg, 32'h0000_0400);
    rd(8'h00, 32'h0000_0400, 1'b0);

    wr(8'h00, 32'h0, 1'b0);
    chk("dur_zero_clamp", rst_ctl_reg, 32'h0000_0008);
    rd(8'h08, 32'h4, 1'b0);
    wr(8'h08, 32'h4, 1'b0);
    rd(8'h08, 32'h0, 1'b0);

    pulse_read(1, 32'h1);
    wr(8'h08, 32'h2, 1'b0);
    pulse_read(2, 32'h0);
    wr(8'h08, 32'h2, 1'b0);
    pulse_read(3, 32'h2);

    fork
      pulse();
      begin
        repeat (2) tick();
        wr(8'h08, 32'h2, 1'b0);
      end
    join
    rd(8'h08, 32'h2, 1'b0);
    wr(8'h08, 32'h2, 1'b0);
    rd(8'h08, 32'h0, 1'b0);

    wr(8'h04, 32'h0000_005A, 1'b0);
    chk("clk_ctl_write", {24'b0, clk_ctl_reg}, 32'h0000_005A);
    rd(8'h04, 32'h0000_005A, 1'b0);

    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h0;
    repeat (6) begin
      tick();
      chk("no_setup_pready", {31'b0, pready}, 32'h0);
    end
    psel = 1'b0; penable = 1'b0;
    tick();
    chk("no_setup_commit", {24'b0, clk_ctl_reg}, 32'h0000_005A);
    rd(8'h04, 32'h0000_005A, 1'b0);

    wr(8'h0C, 32'hFFFF_FFFF, ERR_EN);
    chk("id_write_rst_ctl", rst_ctl_reg, 32'h0000_0008);
    chk("id_write_clk_ctl", {24'b0, clk_ctl_reg}, 32'h0000_005A);
    rd(8'h10, 32'h0, ERR_EN);
    rd(8'h0C, ID, 1'b0);
    wr(8'h00, 32'h0, 1'b0);
    wr(8'h08, 32'h5, ERR_EN);
    rd(8'h08, ERR_EN ? 32'h4 : 32'h0, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
